link_tx_train: RTL and testbench
================================

Name: link_tx_train

Overview:
- Transmit-side link trainer for the parallel serial-link path.
- Drives a W-bit word stream to the serializer.
- After start, sends alternating 0x5…/0xA… training words until the far-end word aligner reports lock. It then sends guard words and passes user data with a valid/ready handshake.
- Sits between the user TX datapath and the SERDES TX parallel input, mirroring the receive-side aligner.

Parameters:
- W, 128: word width. Must be a multiple of 8.
- TRAIN_MIN, 64: minimum training words before lock is accepted. Even, ≥2.
- GUARD_WORDS, 8: training words sent after lock is accepted. Even, ≥2.
- TIMEOUT, 4096: training words without lock before train_fail pulses. Must be > TRAIN_MIN.
- IDLE_WORD, 0: fill word in DATA with no valid input. Must differ from both training words.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous reset, active-high
- start  in  1  level; 1 = bring link up, 0 = return to idle
- remote_aligned  in  1  far-end aligner lock, already synchronized to clock
- in_data  in  W  user word, bit 0 = MSB ([0:W-1] ordering)
- in_valid  in  1  in_data valid
- in_ready  out  1  DATA state; word accepted when in_valid&&in_ready
- odata  out  W  registered word to serializer, [0:W-1]
- training  out  1  high in TRAIN and GUARD
- link_up  out  1  high in DATA
- train_fail  out  1  one-cycle pulse per TIMEOUT words without lock

Behaviour:
- Training words: PAT_A = {W/4{4'h5}}, PAT_B = {W/4{4'hA}}.
- All outputs are registered. On reset: state=IDLE, odata=0, in_ready=0, training=0, link_up=0, train_fail=0, counters=0, phase=A.
- States: IDLE, TRAIN, GUARD, DATA.
- start=0 sampled in any state → IDLE next cycle, odata=0. This has priority over every other condition.
- IDLE:
  - odata=0.
  - start=1 sampled → TRAIN. The first odata=PAT_A appears the next cycle.
- TRAIN:
  - odata alternates PAT_A, PAT_B every cycle, always starting with PAT_A.
  - word_cnt increments per emitted word and saturates at TRAIN_MIN.
  - Exit to GUARD when all three hold in the same cycle: word_cnt ≥ TRAIN_MIN, remote_aligned=1, and the word being emitted this cycle is PAT_B. The A/B pair is therefore always complete.
  - to_cnt increments per word. At to_cnt = TIMEOUT-1: train_fail pulses for 1 cycle, to_cnt clears, and training continues without restarting the phase.
- GUARD:
  - Alternation continues with PAT_A.
  - After exactly GUARD_WORDS words, go to DATA.
  - remote_aligned is ignored in this state.
- DATA:
  - in_ready=1 in the same cycle as link_up=1.
  - Accepted word appears on odata 1 cycle later.
  - No accept → odata=IDLE_WORD.
  - training=0. Counters and phase are cleared on entry.
- Transitions out of DATA clear in_ready in the same cycle link_up clears. No word is accepted in that cycle.
- reset mid-operation returns to the reset values immediately. Any in-flight word is dropped.

Optional Feature:
- Macro: LINK_TX_RETRAIN_EN.
- Defined: in DATA, remote_aligned=0 sampled on 2 consecutive cycles → TRAIN. On that transition, counters clear and phase=A. in_ready drops the same cycle link_up drops.
- Undefined: remote_aligned is ignored outside TRAIN. DATA is left only via start=0 or reset.

Decomposition:
- Shared package link_pkg holds:
  - tx_state_e enum {IDLE, TRAIN, GUARD, DATA}
  - NIB_5=4'h5 and NIB_A=4'hA, the same constants the receive aligner uses to build its patterns
- Sub-module link_pat_gen generates the training words:
  - inputs: clear, advance
  - outputs: W-bit word and phase_is_b
  - alternates PAT_A/PAT_B

Test Plan (W=128, TRAIN_MIN=8, GUARD_WORDS=4, TIMEOUT=32, IDLE_WORD=0):
- Reset, then start=1 with remote_aligned=1 throughout:
  - odata=0x5555…, 0xAAAA… alternating for 8 words, then 4 guard words.
  - link_up=1 on cycle 13 after start was sampled.
  - in_ready=1 from that same cycle.
- remote_aligned rises on training word 9 (a PAT_A) → GUARD begins only after word 10 (PAT_B). Check with a word-by-word odata scoreboard.
- remote_aligned held 0 for 70 words → train_fail pulses after words 32 and 64 exactly, odata alternation is unbroken, link_up stays 0.
- In DATA, drive in_data=0x0123…CDEF with valid on alternate cycles → odata shows each word 1 cycle later and 0 on idle cycles, with no drops or duplicates.
- start=0 mid-GUARD, and separately reset=1 mid-DATA → next cycle odata=0, in_ready=0, link_up=0, training=0. A re-start begins with PAT_A.
- LINK_TX_RETRAIN_EN defined:
  - remote_aligned=0 for 1 cycle in DATA → no change.
  - remote_aligned=0 for 2 cycles → TRAIN, odata=PAT_A, in_ready=0.
- Same stimulus with the macro undefined → DATA holds and link_up stays 1.

Source files
------------

// File: rtl/link_pkg.sv
// Shared definitions for the serial-link transmit trainer and its receive-side
// counterpart: FSM state encoding and the nibbles used to build training words.
package link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRAIN,
    GUARD,
    DATA
  } tx_state_e;

  localparam logic [3:0] NIB_5 = 4'h5;
  localparam logic [3:0] NIB_A = 4'hA;

endpackage

// File: rtl/link_pat_gen.sv
// Training word generator: alternates PAT_A (0x55..) and PAT_B (0xAA..).
// The phase register restarts at PAT_A on clear, and flips on each advance.
module link_pat_gen
  import link_pkg::*;
#(
  parameter int W = 128
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         advance,
  output logic [0:W-1] word,
  output logic         phase_is_b
);

  localparam logic [0:W-1] PAT_A = {(W/4){NIB_5}};
  localparam logic [0:W-1] PAT_B = {(W/4){NIB_A}};

  // Phase toggles once per emitted word; clear wins so every restart begins on PAT_A
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      phase_is_b <= 1'b0;
    end else if (advance) begin
      phase_is_b <= ~phase_is_b;
    end
  end

  // Word is a pure function of the phase so the top can register it directly
  always_comb begin
    word = phase_is_b ? PAT_B : PAT_A;
  end

endmodule

// File: rtl/link_tx_train.sv
// Transmit-side link trainer. Sends alternating training words until the far
// end reports lock, then guard words, then user data via valid/ready.
// Optional feature: define LINK_TX_RETRAIN_EN to fall back to TRAIN when the
// far-end lock is lost for two consecutive cycles while in DATA.
module link_tx_train
  import link_pkg::*;
#(
  parameter int           W           = 128,
  parameter int           TRAIN_MIN   = 64,
  parameter int           GUARD_WORDS = 8,
  parameter int           TIMEOUT     = 4096,
  parameter logic [0:W-1] IDLE_WORD   = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         remote_aligned,
  input  logic [0:W-1] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [0:W-1] odata,
  output logic         training,
  output logic         link_up,
  output logic         train_fail
);

  localparam int WCW = $clog2(TRAIN_MIN + 1);
  localparam int TOW = $clog2(TIMEOUT);
  localparam int GCW = $clog2(GUARD_WORDS);

  localparam logic [WCW-1:0] TRAIN_MIN_C  = WCW'(TRAIN_MIN);
  localparam logic [TOW-1:0] TIMEOUT_LAST = TOW'(TIMEOUT - 1);
  localparam logic [GCW-1:0] GUARD_LAST   = GCW'(GUARD_WORDS - 1);

  tx_state_e      state;
  logic [WCW-1:0] word_cnt;
  logic [WCW-1:0] word_cnt_inc;
  logic [TOW-1:0] to_cnt;
  logic [GCW-1:0] guard_cnt;
  logic [0:W-1]   pat_word;
  logic           pat_is_b;
  logic           pat_clear;
  logic           pat_advance;
  logic           in_tg;
  logic           train_exit;
  logic           guard_last;
  logic           accept;
  logic           retrain_now;

  link_pat_gen #(
    .W(W)
  ) u_pat_gen (
    .clock      (clock),
    .reset      (reset),
    .clear      (pat_clear),
    .advance    (pat_advance),
    .word       (pat_word),
    .phase_is_b (pat_is_b)
  );

  // Next-step decisions shared by the FSM and the pattern generator controls
  always_comb begin
    word_cnt_inc = (word_cnt == TRAIN_MIN_C) ? word_cnt : word_cnt + 1'b1;
    in_tg        = (state == TRAIN) || (state == GUARD);
    train_exit   = (state == TRAIN) && (word_cnt_inc == TRAIN_MIN_C) &&
                   remote_aligned && pat_is_b;
    guard_last   = (state == GUARD) && (guard_cnt == GUARD_LAST);
    accept       = (state == DATA) && in_ready && in_valid;
    pat_advance  = start && in_tg;
    pat_clear    = !start || !in_tg || guard_last;
  end

`ifdef LINK_TX_RETRAIN_EN
  logic lost_q;

  // Remembers that lock was missing last cycle while in DATA
  always_ff @(posedge clock) begin
    if (reset || !start || (state != DATA) || retrain_now) begin
      lost_q <= 1'b0;
    end else begin
      lost_q <= !remote_aligned;
    end
  end

  // Second consecutive missing-lock sample in DATA sends the link back to TRAIN
  always_comb begin
    retrain_now = (state == DATA) && !remote_aligned && lost_q;
  end
`else
  // Without retraining, DATA is only left through start=0 or reset
  always_comb begin
    retrain_now = 1'b0;
  end
`endif

  // Main FSM with registered outputs; start=0 forces idle ahead of everything else
  always_ff @(posedge clock) begin
    if (reset || !start) begin
      state      <= IDLE;
      odata      <= '0;
      in_ready   <= 1'b0;
      training   <= 1'b0;
      link_up    <= 1'b0;
      train_fail <= 1'b0;
      word_cnt   <= '0;
      to_cnt     <= '0;
      guard_cnt  <= '0;
    end else begin
      train_fail <= 1'b0;
      case (state)
        IDLE: begin
          state     <= TRAIN;
          odata     <= '0;
          in_ready  <= 1'b0;
          training  <= 1'b0;
          link_up   <= 1'b0;
          word_cnt  <= '0;
          to_cnt    <= '0;
          guard_cnt <= '0;
        end
        TRAIN: begin
          odata    <= pat_word;
          training <= 1'b1;
          link_up  <= 1'b0;
          in_ready <= 1'b0;
          if (train_exit) begin
            state     <= GUARD;
            word_cnt  <= '0;
            to_cnt    <= '0;
            guard_cnt <= '0;
          end else begin
            word_cnt <= word_cnt_inc;
            if (to_cnt == TIMEOUT_LAST) begin
              train_fail <= 1'b1;
              to_cnt     <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        GUARD: begin
          odata    <= pat_word;
          training <= 1'b1;
          if (guard_last) begin
            state     <= DATA;
            guard_cnt <= '0;
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end
        DATA: begin
          // A handshake that completes on the retrain edge is still forwarded
          odata    <= accept ? in_data : IDLE_WORD;
          training <= 1'b0;
          if (retrain_now) begin
            state    <= TRAIN;
            link_up  <= 1'b0;
            in_ready <= 1'b0;
          end else begin
            link_up  <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          odata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_link_tx_train.sv
// Directed testbench for link_tx_train with W=128, TRAIN_MIN=8, GUARD_WORDS=4,
// TIMEOUT=32, IDLE_WORD=0. Expectations for LINK_TX_RETRAIN_EN follow the macro.
module tb_link_tx_train;

  localparam logic [0:127] PAT_A     = {32{4'h5}};
  localparam logic [0:127] PAT_B     = {32{4'hA}};
  localparam logic [0:127] DATA_BASE = 128'h0123456789ABCDEF0123456789ABCDEF;

  logic         clock;
  logic         reset;
  logic         start;
  logic         remote_aligned;
  logic [0:127] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] odata;
  logic         training;
  logic         link_up;
  logic         train_fail;

  int           testsRun;
  int           failCount;
  logic [0:127] word;
  logic         v;

  link_tx_train #(
    .W           (128),
    .TRAIN_MIN   (8),
    .GUARD_WORDS (4),
    .TIMEOUT     (32),
    .IDLE_WORD   ('0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .remote_aligned (remote_aligned),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .odata          (odata),
    .training       (training),
    .link_up        (link_up),
    .train_fail     (train_fail)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive inputs, then let one active edge pass and settle before sampling
  task automatic applyStimulus(input logic s, input logic ra, input logic vld,
                               input logic [0:127] d);
    start          = s;
    remote_aligned = ra;
    in_valid       = vld;
    in_data        = d;
    @(posedge clock);
    #1;
  endtask

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Idle for one cycle, then train with lock present until link_up appears
  task automatic bringUpToData();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    for (int k = 0; k <= 13; k++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("bringup_link_up", link_up, 1'b1);
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("rst_odata", odata, '0);
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_training", training, 1'b0);
    checkOutput("rst_link_up", link_up, 1'b0);
    checkOutput("rst_train_fail", train_fail, 1'b0);
    reset = 1'b0;

    $display("[TB] bring-up with lock held high");
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("up_e0_odata", odata, '0);
    checkOutput("up_e0_training", training, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      if (k <= 12) begin
        checkOutput("up_odata", odata, (k % 2 == 1) ? PAT_A : PAT_B);
        checkOutput("up_training", training, 1'b1);
        checkOutput("up_link_up", link_up, 1'b0);
        checkOutput("up_in_ready", in_ready, 1'b0);
      end else begin
        checkOutput("up13_link_up", link_up, 1'b1);
        checkOutput("up13_in_ready", in_ready, 1'b1);
        checkOutput("up13_training", training, 1'b0);
        checkOutput("up13_odata", odata, '0);
      end
    end

    $display("[TB] lock arrives on training word 9");
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("late_idle_link_up", link_up, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(1'b1, (k >= 9), 1'b0, '0);
      if (k <= 14) checkOutput("late_odata", odata, (k % 2 == 1) ? PAT_A : PAT_B);
      checkOutput("late_link_up", link_up, (k >= 15));
      checkOutput("late_training", training, (k <= 14));
    end

    $display("[TB] no lock for 70 words");
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int k = 1; k <= 70; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      checkOutput("to_odata", odata, (k % 2 == 1) ? PAT_A : PAT_B);
      checkOutput("to_train_fail", train_fail, (k == 32) || (k == 64));
      checkOutput("to_link_up", link_up, 1'b0);
    end

    $display("[TB] data transfer on alternate cycles");
    bringUpToData();
    for (int i = 0; i < 8; i++) begin
      word = DATA_BASE + 128'(i);
      v    = (i % 2 == 0);
      applyStimulus(1'b1, 1'b1, v, word);
      checkOutput("data_odata", odata, v ? word : '0);
      checkOutput("data_in_ready", in_ready, 1'b1);
    end

    $display("[TB] start dropped during guard");
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    for (int k = 0; k <= 10; k++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("mg_pre_training", training, 1'b1);
    checkOutput("mg_pre_odata", odata, PAT_B);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("mg_odata", odata, '0);
    checkOutput("mg_in_ready", in_ready, 1'b0);
    checkOutput("mg_link_up", link_up, 1'b0);
    checkOutput("mg_training", training, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("mg_restart_odata", odata, PAT_A);

    $display("[TB] reset during data");
    bringUpToData();
    applyStimulus(1'b1, 1'b1, 1'b1, DATA_BASE);
    checkOutput("md_word", odata, DATA_BASE);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, ~DATA_BASE);
    checkOutput("md_odata", odata, '0);
    checkOutput("md_in_ready", in_ready, 1'b0);
    checkOutput("md_link_up", link_up, 1'b0);
    checkOutput("md_training", training, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("md_restart_e0", odata, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("md_restart_odata", odata, PAT_A);

    $display("[TB] lock loss while in data");
    bringUpToData();
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("ll1_link_up", link_up, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("ll1_hold_link_up", link_up, 1'b1);
    checkOutput("ll1_hold_in_ready", in_ready, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
`ifdef LINK_TX_RETRAIN_EN
    checkOutput("ll2_link_up", link_up, 1'b0);
    checkOutput("ll2_in_ready", in_ready, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("ll2_odata", odata, PAT_A);
    checkOutput("ll2_training", training, 1'b1);
`else
    checkOutput("ll2_link_up", link_up, 1'b1);
    checkOutput("ll2_in_ready", in_ready, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("ll2_odata", odata, '0);
    checkOutput("ll2_training", training, 1'b0);
    checkOutput("ll2_hold_link_up", link_up, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
